// File: rtl/morph_rank_filter.sv
// 3x3 rank-order filter for a binary pixel stream (bypass, dilation, median, erosion).
// Optional MORPH_FG_COUNT_EN adds a per-frame foreground pixel counter on fg_count.
module morph_rank_filter #(
   parameter int unsigned IMG_HDISP = 640,
   parameter int unsigned IMG_VDISP = 480
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        per_frame_vsync,
   input  logic        per_frame_href,
   input  logic        per_frame_clken,
   input  logic        per_img_Bit,
   input  logic [3:0]  rank,
   output logic        post_frame_vsync,
   output logic        post_frame_href,
   output logic        post_frame_clken,
   output logic        post_img_Bit,
   output logic        fmt_err,
   output logic [19:0] fg_count
);

   localparam int unsigned CW = $clog2(IMG_HDISP + 1) + 1;
   localparam int unsigned RW = $clog2(IMG_VDISP + 1) + 1;
   localparam int unsigned AW = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
   localparam logic [CW-1:0] HMAX = CW'(IMG_HDISP);
   localparam logic [RW-1:0] VMAX = RW'(IMG_VDISP);

   logic          vsync_q, href_q, active_q, err_q;
   logic          vsync_rise, vsync_fall, href_rise, href_fall;
   logic [CW-1:0] col_q, col_cur, col_nxt;
   logic [RW-1:0] row_q, row_cur, row_nxt;
   logic          in_range, err_set;
   logic [AW-1:0] lb_addr;
   logic [3:0]    rank_q, thr, pop;
   logic          lb0 [IMG_HDISP];
   logic          lb1 [IMG_HDISP];
   logic [2:0]    s1_col;
   logic          s1_clken, s1_valid, s1_col0, s1_col1;
   logic [2:0]    win0, win1, win2;
   logic          s2_valid, filt;
   logic [2:0]    vs_pipe, hr_pipe, ck_pipe;

   always_comb begin
      vsync_rise = per_frame_vsync & ~vsync_q;
      vsync_fall = ~per_frame_vsync & vsync_q;
      href_rise  = per_frame_href & ~href_q;
      href_fall  = ~per_frame_href & href_q;
      col_cur    = href_rise ? '0 : col_q;
      row_cur    = vsync_rise ? '0 : row_q;
      col_nxt    = col_cur;
      if (per_frame_clken && col_cur != '1) col_nxt = col_cur + 1'b1;
      row_nxt    = row_cur;
      if (href_fall && row_cur != '1) row_nxt = row_cur + 1'b1;
      in_range   = col_cur < HMAX;
      lb_addr    = col_cur[AW-1:0];
      err_set    = active_q & ((per_frame_clken & ~in_range) |
                               (href_fall & (col_cur != HMAX)) |
                               (vsync_fall & (row_nxt != VMAX)));
   end

   // Edge detectors reset high so a reset released mid-frame never fakes a vsync rise.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         vsync_q  <= 1'b1;
         href_q   <= 1'b1;
         active_q <= 1'b0;
         err_q    <= 1'b0;
         col_q    <= '0;
         row_q    <= '0;
         rank_q   <= '0;
      end else begin
         vsync_q  <= per_frame_vsync;
         href_q   <= per_frame_href;
         active_q <= active_q | vsync_rise;
         err_q    <= vsync_rise ? 1'b0 : (err_q | err_set);
         col_q    <= col_nxt;
         row_q    <= row_nxt;
         if (vsync_rise) rank_q <= rank;
      end
   end

   assign fmt_err = err_q;

   // lb0 holds row r-1, lb1 row r-2; read-before-write shifts a column down one row.
   always_ff @(posedge sys_clk) begin
      if (per_frame_clken && in_range) begin
         lb0[lb_addr] <= per_img_Bit;
         lb1[lb_addr] <= lb0[lb_addr];
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         s1_col   <= '0;
         s1_clken <= 1'b0;
         s1_valid <= 1'b0;
         s1_col0  <= 1'b0;
         s1_col1  <= 1'b0;
         win0     <= '0;
         win1     <= '0;
         win2     <= '0;
         s2_valid <= 1'b0;
      end else begin
         s1_col   <= {(row_cur >= RW'(2)) & lb1[lb_addr], (row_cur != '0) & lb0[lb_addr],
                      per_img_Bit};
         s1_clken <= per_frame_clken;
         s1_valid <= (active_q | vsync_rise) & in_range;
         s1_col0  <= col_cur == '0;
         s1_col1  <= col_cur == CW'(1);
         if (s1_clken) begin
            win0 <= s1_col;
            win1 <= s1_col0 ? '0 : win0;
            win2 <= (s1_col0 | s1_col1) ? '0 : win1;
         end
         s2_valid <= s1_clken & s1_valid;
      end
   end

   always_comb begin
      pop = '0;
      for (int i = 0; i < 3; i++) begin
         pop = pop + {3'b0, win0[i]} + {3'b0, win1[i]} + {3'b0, win2[i]};
      end
      thr  = (rank_q > 4'd9) ? 4'd9 : rank_q;
      filt = (thr == 4'd0) ? win1[1] : (pop >= thr);
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         vs_pipe      <= '0;
         hr_pipe      <= '0;
         ck_pipe      <= '0;
         post_img_Bit <= 1'b0;
      end else begin
         vs_pipe      <= {vs_pipe[1:0], per_frame_vsync};
         hr_pipe      <= {hr_pipe[1:0], per_frame_href};
         ck_pipe      <= {ck_pipe[1:0], per_frame_clken};
         post_img_Bit <= s2_valid & filt;
      end
   end

   assign post_frame_vsync = vs_pipe[2];
   assign post_frame_href  = hr_pipe[2];
   assign post_frame_clken = ck_pipe[2];

`ifdef MORPH_FG_COUNT_EN
   logic [19:0] fg_acc;
   logic [19:0] fg_acc_inc;
   logic        post_vs_q;

   assign fg_acc_inc = (post_img_Bit && fg_acc != '1) ? fg_acc + 20'd1 : fg_acc;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         fg_acc    <= '0;
         fg_count  <= '0;
         post_vs_q <= 1'b0;
      end else begin
         post_vs_q <= post_frame_vsync;
         if (post_vs_q && !post_frame_vsync) begin
            fg_count <= fg_acc_inc;
            fg_acc   <= '0;
         end else begin
            fg_acc <= fg_acc_inc;
         end
      end
   end
`else
   assign fg_count = '0;
`endif

endmodule

// File: doc/morph_rank_filter.md
MORPH_RANK_FILTER -- requirements
Module: morph_rank_filter

Interface
REQ-001 SHALL have parameter IMG_HDISP, default 640: active pixels per line.
REQ-002 SHALL have parameter IMG_VDISP, default 480: active lines per frame.
REQ-003 SHALL have port sys_clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port sys_rst, input, 1: asynchronous active-high reset.
REQ-005 SHALL have ports per_frame_vsync/per_frame_href/per_frame_clken, input, 1 each: input frame, line and pixel strobes.
REQ-006 SHALL have port per_img_Bit, input, 1: binary input pixel, valid when per_frame_clken=1.
REQ-007 SHALL have port rank, input, 4: threshold code (0 bypass, 1 dilation, 9 erosion, 5 median).
REQ-008 SHALL have ports post_frame_vsync/post_frame_href/post_frame_clken, output, 1 each: delayed strobes.
REQ-009 SHALL have port post_img_Bit, output, 1: filtered pixel.
REQ-010 SHALL have port fmt_err, output, 1: sticky frame-geometry error.
REQ-011 SHALL have port fg_count, output, 20: foreground pixel count of the last output frame.

Function
REQ-012 post_frame_vsync/href/clken SHALL equal per_frame_vsync/href/clken delayed exactly 3 sys_clk cycles.
REQ-013 Two IMG_HDISP x 1-bit line buffers SHALL be written only on per_frame_clken with column index < IMG_HDISP.
REQ-014 Column counter SHALL clear on per_frame_href rising edge and increment per clken; row counter SHALL clear on per_frame_vsync rising edge and increment per href falling edge.
REQ-015 Output for input pixel (r,c) SHALL use the 3x3 window rows r-2..r, cols c-2..c; taps with row<0 or col<0 SHALL read 0.
REQ-016 For rank 1..9: post_img_Bit = 1 iff popcount(window) >= rank; rank 10..15 SHALL behave as 9.
REQ-017 For rank 0: post_img_Bit SHALL equal the window centre tap (row r-1, col c-1), 0 if outside.
REQ-018 rank SHALL be sampled on per_frame_vsync rising edge only; mid-frame changes have no effect until next frame.
REQ-019 post_img_Bit SHALL be 0 whenever post_frame_clken=0.
REQ-020 Pixels beyond IMG_HDISP in a line SHALL produce post_img_Bit=0 and set fmt_err.
REQ-021 fmt_err SHALL set on a line with clken count != IMG_HDISP or a frame with line count != IMG_VDISP; SHALL clear only on vsync rising edge or reset.
REQ-022 Simultaneous vsync rising edge and error detection SHALL clear then not set (new frame wins).

Reset
REQ-023 On sys_rst=1 all post_* outputs, fmt_err and fg_count SHALL be 0 asynchronously; counters cleared; sampled rank = 0.
REQ-024 Line buffer contents SHALL not require reset; first two rows after reset SHALL be masked by REQ-015.
REQ-025 Reset mid-frame SHALL discard the frame; processing resumes at next vsync rising edge.

Configuration
REQ-026 Macro MORPH_FG_COUNT_EN: when defined, a counter SHALL increment per post_img_Bit=1 and fg_count SHALL latch it on post_frame_vsync falling edge, counter then clearing; saturate at 2^20-1.
REQ-027 Without MORPH_FG_COUNT_EN, fg_count SHALL be constant 0 and no counter logic present.

Verification
REQ-028 IMG 8x6, rank=9, all-ones frame -> post_img_Bit=1 only where r>=2 and c>=2; 0 elsewhere; fmt_err=0.
REQ-029 IMG 8x6, rank=1, single 1 at (2,3) -> ones at outputs r 2..4, c 3..5 (9 pixels); with macro fg_count=9.
REQ-030 rank=0 bypass, random frame -> output at (r,c) equals input (r-1,c-1); strobes delayed 3 cycles.
REQ-031 rank changed 1->9 mid-frame -> current frame stays dilation; next frame erosion.
REQ-032 Line of 9 pixels with IMG_HDISP=8 -> 9th output 0, fmt_err=1 until next vsync rising edge.
REQ-033 sys_rst pulse mid-frame -> all outputs 0 same cycle; next full frame matches REQ-028 result.
